// File: rtl/serial_neighbor_counter.sv
// Bit-serial Game-of-Life cell evaluator: accumulates 8 neighbour bits through a
// ripple chain of 1-bit full adders, then applies the Conway rule.

module adder_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_neighbor_counter #(
  parameter int N_NEIGHBORS = 8,
  parameter int COUNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_NEIGHBORS-1:0] neighbors,
  input  logic                   alive_in,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_W-1:0]     count,
  output logic                   next_alive
);
  localparam int IDX_W = (N_NEIGHBORS > 1) ? $clog2(N_NEIGHBORS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEIGHBORS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [N_NEIGHBORS-1:0]   neigh_q, neigh_d;
  logic                     alive_q, alive_d;
  logic [COUNT_W-1:0]       acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [COUNT_W-1:0]       count_q, count_d;
  logic                     next_alive_q, next_alive_d;
  logic                     done_q, done_d;

  logic [COUNT_W-1:0]       carry_s;
  logic [COUNT_W-1:0]       acc_sum_s;
  logic                     carry_unused_s;

  // Incrementer: the selected neighbour bit enters as carry-in of bit 0.
  assign carry_s[0] = neigh_q[idx_q];

  for (genvar i = 0; i < COUNT_W; i++) begin : g_chain
    if (i < COUNT_W - 1) begin : g_mid
      adder_1 u_add (
        .a   (acc_q[i]),
        .b   (1'b0),
        .cin (carry_s[i]),
        .s   (acc_sum_s[i]),
        .cout(carry_s[i+1])
      );
    end else begin : g_top
      adder_1 u_add (
        .a   (acc_q[i]),
        .b   (1'b0),
        .cin (carry_s[i]),
        .s   (acc_sum_s[i]),
        .cout(carry_unused_s)
      );
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    neigh_d      = neigh_q;
    alive_d      = alive_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    count_d      = count_q;
    next_alive_d = next_alive_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          neigh_d = neighbors;
          alive_d = alive_in;
          acc_d   = {COUNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        acc_d = acc_sum_s;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = RESOLVE;
        end else begin
          state_d = ACCUM;
        end
      end
      RESOLVE: begin
        count_d      = acc_q;
        next_alive_d = (alive_q & ((acc_q == COUNT_W'(2)) | (acc_q == COUNT_W'(3))))
                     | (~alive_q & (acc_q == COUNT_W'(3)));
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      neigh_q      <= {N_NEIGHBORS{1'b0}};
      alive_q      <= 1'b0;
      acc_q        <= {COUNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      count_q      <= {COUNT_W{1'b0}};
      next_alive_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      neigh_q      <= neigh_d;
      alive_q      <= alive_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      next_alive_q <= next_alive_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign count      = count_q;
  assign next_alive = next_alive_q;

endmodule

// File: tb/tb_serial_neighbor_counter.sv
// Directed scoreboard bench for serial_neighbor_counter: expectations are pushed
// when a start is accepted and popped when done is observed.

module tb_serial_neighbor_counter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] neighbors;
  logic       alive_in;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       next_alive;

  typedef struct packed {
    logic [3:0] cnt;
    logic       alive;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  serial_neighbor_counter #(.N_NEIGHBORS(8), .COUNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .neighbors (neighbors),
    .alive_in  (alive_in),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .next_alive(next_alive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] nb, input logic al);
    exp_t e;
    int   n;
    n = $countones(nb);
    e.cnt   = 4'(n);
    e.alive = (al && (n == 2 || n == 3)) || (!al && n == 3);
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic begin_eval(input logic [7:0] nb, input logic al, input bit push);
    neighbors = nb;
    alive_in  = al;
    start     = 1'b1;
    if (push) sb_q.push_back(model(nb, al));
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = edges already elapsed since the accepting edge; expects done after edge 9.
  task automatic wait_done(input string tag, input int n0);
    int   n;
    exp_t e;
    int   busy_bad;
    n = n0;
    busy_bad = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_during"}, 8'(busy_bad), 8'd0);
    check({tag, "_latency"}, 8'(n), 8'd9);
    check({tag, "_busy_at_done"}, {7'd0, busy}, 8'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_count"}, {4'd0, count}, {4'd0, e.cnt});
      check({tag, "_next_alive"}, {7'd0, next_alive}, {7'd0, e.alive});
    end else begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end
  endtask

  initial begin
    int dones;
    rst_n     = 1'b0;
    start     = 1'b1;
    neighbors = 8'hFF;
    alive_in  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_count", {4'd0, count}, 8'd0);
    check("rst_next_alive", {7'd0, next_alive}, 8'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_no_eval", {7'd0, busy}, 8'd0);

    // Birth, then hold in IDLE.
    begin_eval(8'b0000_0111, 1'b0, 1'b1);
    wait_done("birth", 0);
    @(negedge clk);
    check("done_one_cycle", {7'd0, done}, 8'd0);
    repeat (3) @(negedge clk);
    check("idle_hold_count", {4'd0, count}, 8'd3);
    check("idle_hold_alive", {7'd0, next_alive}, 8'd1);

    // Back-to-back chain through survival, death and boundary counts.
    begin_eval(8'b1000_0001, 1'b1, 1'b1);
    wait_done("survive2", 0);
    begin_eval(8'b1111_0000, 1'b1, 1'b1);
    wait_done("die4", 0);
    begin_eval(8'b0000_0001, 1'b1, 1'b1);
    wait_done("die1", 0);
    begin_eval(8'hFF, 1'b1, 1'b1);
    wait_done("full8", 0);
    begin_eval(8'h00, 1'b0, 1'b1);
    wait_done("empty0", 0);
    @(negedge clk);

    // Ignored start at edge k+3 and operand churn mid-ACCUM.
    begin_eval(8'b0010_0110, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    start     = 1'b1;
    neighbors = 8'hFF;
    alive_in  = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    neighbors = 8'h00;
    @(negedge clk);
    neighbors = 8'h5A;
    wait_done("ignore_start", 4);
    // Start in the done cycle is accepted with no bubble.
    begin_eval(8'h03, 1'b0, 1'b1);
    wait_done("b2b", 0);
    check("sb_drained", 8'(sb_q.size()), 8'd0);
    @(negedge clk);

    // Reset mid-evaluation at edge k+5.
    begin_eval(8'hFF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_count", {4'd0, count}, 8'd0);
    check("midrst_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("midrst_no_done", 8'(dones), 8'd0);
    begin_eval(8'b1010_1000, 1'b0, 1'b1);
    wait_done("after_rst", 0);
    check("sb_final", 8'(sb_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
